divide_remainder: RTL and testbench

Multi-cycle signed integer divider producing quotient and remainder. It is the inverse companion of the pipelined multiply-add datapath. The numerator port defaults to the multiply-add accumulator width (M1+M2+1 = 33 bits), so accumulated products can be scaled back down by a 16-bit divisor. Operands enter and results leave through valid/ready handshakes. One division is in flight at a time, using an iterative radix-2 restoring algorithm on magnitudes with a final sign correction.

---
 rtl/divide_remainder.sv | 163 ++++++++++++++++
 tb/tb_divide_remainder.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/divide_remainder.sv
// Multi-cycle signed divider: radix-2 restoring division on operand magnitudes,
// followed by a sign-correction step, with valid/ready handshakes on both sides.
module divide_remainder #(
  parameter int N_WIDTH = 33,
  parameter int D_WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_WIDTH-1:0] up_numer,
  input  logic [D_WIDTH-1:0] up_denom,
  input  logic               up_valid,
  output logic               up_ready,
  output logic [N_WIDTH-1:0] dn_quotient,
  output logic [D_WIDTH-1:0] dn_remainder,
  output logic               dn_div_zero,
  output logic               dn_overflow,
  output logic               dn_valid,
  input  logic               dn_ready
);

  localparam int CNT_W = $clog2(N_WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]         state;
  logic [CNT_W-1:0]   count;
  logic [N_WIDTH-1:0] work;
  logic [D_WIDTH-1:0] den_abs;
  logic [D_WIDTH:0]   rem;
  logic               num_neg;
  logic               sign_diff;
  logic               div_zero;
  logic               ovf;

  logic               accept;
  logic [N_WIDTH-1:0] num_abs_in;
  logic [D_WIDTH-1:0] den_abs_in;
  logic               den_is_zero;
  logic               is_ovf_case;
  logic [D_WIDTH:0]   rem_shift;
  logic [D_WIDTH:0]   rem_diff;
  logic               rem_ge;
  logic [D_WIDTH:0]   rem_next;
  logic [N_WIDTH-1:0] quo_fixed;
  logic [D_WIDTH-1:0] rem_fixed;
  logic               unused_rem_msb;

  assign accept = up_valid && up_ready && (state == IDLE);

  // An unsigned N_WIDTH-bit magnitude already holds 2^(N_WIDTH-1), so the
  // most-negative numerator needs no extra bit; the same holds for the divisor.
  always_comb begin
    num_abs_in  = up_numer[N_WIDTH-1] ? -up_numer : up_numer;
    den_abs_in  = up_denom[D_WIDTH-1] ? -up_denom : up_denom;
    den_is_zero = (up_denom == '0);
    is_ovf_case = (up_numer == {1'b1, {(N_WIDTH-1){1'b0}}}) && (up_denom == '1);
  end

  // One restoring step: the next dividend bit comes from the top of work, and
  // the quotient bit is shifted into the bottom of the same register.
  always_comb begin
    rem_shift = {rem[D_WIDTH-1:0], work[N_WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, den_abs};
    rem_ge    = (rem_shift >= {1'b0, den_abs});
    rem_next  = rem_ge ? rem_diff : rem_shift;
    quo_fixed = sign_diff ? -work : work;
    rem_fixed = num_neg ? -rem[D_WIDTH-1:0] : rem[D_WIDTH-1:0];
  end

  // The stored partial remainder is always below the divisor, so its top bit stays clear.
  assign unused_rem_msb = rem[D_WIDTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      count     <= '0;
      work      <= '0;
      den_abs   <= '0;
      rem       <= '0;
      num_neg   <= 1'b0;
      sign_diff <= 1'b0;
      div_zero  <= 1'b0;
      ovf       <= 1'b0;
      up_ready  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            work      <= num_abs_in;
            den_abs   <= den_abs_in;
            num_neg   <= up_numer[N_WIDTH-1];
            sign_diff <= up_numer[N_WIDTH-1] ^ up_denom[D_WIDTH-1];
            div_zero  <= den_is_zero;
            ovf       <= is_ovf_case;
            count     <= '0;
            up_ready  <= 1'b0;
            // A zero divisor parks the raw low dividend bits here and skips iteration.
            if (den_is_zero) begin
              rem   <= {1'b0, up_numer[D_WIDTH-1:0]};
              state <= FIX;
            end else begin
              rem   <= '0;
              state <= CALC;
            end
          end else begin
            up_ready <= 1'b1;
          end
        end
        CALC: begin
          rem   <= rem_next;
          work  <= {work[N_WIDTH-2:0], rem_ge};
          count <= count + CNT_W'(1);
          if (count == CNT_W'(N_WIDTH-1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          state <= DONE;
        end
        DONE: begin
          if (dn_ready) begin
            state    <= IDLE;
            up_ready <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          up_ready <= 1'b0;
        end
      endcase
    end
  end

  // Result registers only change in FIX, so they hold through backpressure.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dn_quotient  <= '0;
      dn_remainder <= '0;
      dn_div_zero  <= 1'b0;
      dn_overflow  <= 1'b0;
      dn_valid     <= 1'b0;
    end else begin
      if (state == FIX) begin
        dn_valid    <= 1'b1;
        dn_div_zero <= div_zero;
        dn_overflow <= ovf;
        if (div_zero) begin
          dn_quotient  <= '1;
          dn_remainder <= rem[D_WIDTH-1:0];
        end else begin
          dn_quotient  <= quo_fixed;
          dn_remainder <= rem_fixed;
        end
      end else if ((state == DONE) && dn_ready) begin
        dn_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_divide_remainder.sv
// Directed bench for divide_remainder: hand-computed quotients/remainders,
// latency, flags, backpressure and asynchronous reset behaviour.
module tb_divide_remainder;

  localparam int N_WIDTH = 33;
  localparam int D_WIDTH = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic [N_WIDTH-1:0] up_numer;
  logic [D_WIDTH-1:0] up_denom;
  logic               up_valid;
  logic               up_ready;
  logic [N_WIDTH-1:0] dn_quotient;
  logic [D_WIDTH-1:0] dn_remainder;
  logic               dn_div_zero;
  logic               dn_overflow;
  logic               dn_valid;
  logic               dn_ready;

  int total = 0;
  int bad   = 0;
  int lat   = 0;

  divide_remainder #(.N_WIDTH(N_WIDTH), .D_WIDTH(D_WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .up_numer    (up_numer),
    .up_denom    (up_denom),
    .up_valid    (up_valid),
    .up_ready    (up_ready),
    .dn_quotient (dn_quotient),
    .dn_remainder(dn_remainder),
    .dn_div_zero (dn_div_zero),
    .dn_overflow (dn_overflow),
    .dn_valid    (dn_valid),
    .dn_ready    (dn_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Presents one operand pair, takes the accept edge, then counts edges until dn_valid.
  task automatic applyStimulus(input logic [N_WIDTH-1:0] numer, input logic [D_WIDTH-1:0] denom,
                               input logic ready_val);
    checkOutput("ready_before_accept", 64'(up_ready), 64'd1);
    up_numer = numer;
    up_denom = denom;
    up_valid = 1'b1;
    dn_ready = ready_val;
    tick();
    up_valid = 1'b0;
    checkOutput("ready_low_after_accept", 64'(up_ready), 64'd0);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!dn_valid && lat < 60);
  endtask

  task automatic checkResult(input string tag, input logic [N_WIDTH-1:0] q, input logic [D_WIDTH-1:0] r,
                             input logic dz, input logic ov, input int exp_lat);
    checkOutput({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    checkOutput({tag, "_valid"}, 64'(dn_valid), 64'd1);
    checkOutput({tag, "_quotient"}, 64'(dn_quotient), 64'(q));
    checkOutput({tag, "_remainder"}, 64'(dn_remainder), 64'(r));
    checkOutput({tag, "_div_zero"}, 64'(dn_div_zero), 64'(dz));
    checkOutput({tag, "_overflow"}, 64'(dn_overflow), 64'(ov));
  endtask

  task automatic finishHandshake(input string tag);
    dn_ready = 1'b1;
    tick();
    checkOutput({tag, "_valid_drop"}, 64'(dn_valid), 64'd0);
    checkOutput({tag, "_ready_back"}, 64'(up_ready), 64'd1);
  endtask

  initial begin
    rst      = 1'b0;
    up_numer = '0;
    up_denom = '0;
    up_valid = 1'b0;
    dn_ready = 1'b0;

    // Reset state, then ready on the first edge after release
    #2;
    checkOutput("reset_up_ready", 64'(up_ready), 64'd0);
    checkOutput("reset_dn_valid", 64'(dn_valid), 64'd0);
    checkOutput("reset_quotient", 64'(dn_quotient), 64'd0);
    checkOutput("reset_remainder", 64'(dn_remainder), 64'd0);
    checkOutput("reset_flags", 64'({dn_div_zero, dn_overflow}), 64'd0);
    tick();
    tick();
    checkOutput("reset_held_up_ready", 64'(up_ready), 64'd0);
    rst = 1'b1;
    tick();
    checkOutput("release_up_ready", 64'(up_ready), 64'd1);

    applyStimulus(33'd100, 16'd7, 1'b1);
    checkResult("p100_d7", 33'd14, 16'd2, 1'b0, 1'b0, 34);
    finishHandshake("p100_d7");

    applyStimulus(-33'sd100, 16'd7, 1'b1);
    checkResult("n100_d7", 33'h1_FFFF_FFF2, 16'hFFFE, 1'b0, 1'b0, 34);
    finishHandshake("n100_d7");

    applyStimulus(33'd100, -16'sd7, 1'b1);
    checkResult("p100_nd7", 33'h1_FFFF_FFF2, 16'd2, 1'b0, 1'b0, 34);
    finishHandshake("p100_nd7");

    applyStimulus(-33'sd100, -16'sd7, 1'b1);
    checkResult("n100_nd7", 33'd14, 16'hFFFE, 1'b0, 1'b0, 34);
    finishHandshake("n100_nd7");

    applyStimulus(33'h1_0000_0000, 16'h8000, 1'b1);
    checkResult("minn_mind", 33'd131072, 16'd0, 1'b0, 1'b0, 34);
    finishHandshake("minn_mind");

    applyStimulus(33'd5, 16'd0, 1'b1);
    checkResult("p5_zero", 33'h1_FFFF_FFFF, 16'd5, 1'b1, 1'b0, 1);
    finishHandshake("p5_zero");

    applyStimulus(-33'sd70000, 16'd0, 1'b1);
    checkResult("n70000_zero", 33'h1_FFFF_FFFF, 16'hEE90, 1'b1, 1'b0, 1);
    finishHandshake("n70000_zero");

    applyStimulus(33'h1_0000_0000, 16'hFFFF, 1'b1);
    checkResult("overflow", 33'h1_0000_0000, 16'd0, 1'b0, 1'b1, 34);
    finishHandshake("overflow");

    // Backpressure: result must hold while the upstream side churns
    applyStimulus(33'd200, 16'd9, 1'b0);
    checkResult("bp_200_9", 33'd22, 16'd2, 1'b0, 1'b0, 34);
    for (int i = 0; i < 10; i++) begin
      up_numer = 33'(i * 37 + 1);
      up_denom = 16'(i + 1);
      up_valid = i[0];
      tick();
      checkOutput("bp_quotient", 64'(dn_quotient), 64'd22);
      checkOutput("bp_remainder", 64'(dn_remainder), 64'd2);
      checkOutput("bp_dn_valid", 64'(dn_valid), 64'd1);
      checkOutput("bp_up_ready", 64'(up_ready), 64'd0);
    end
    up_valid = 1'b0;
    finishHandshake("bp_200_9");

    applyStimulus(33'd50, -16'sd6, 1'b1);
    checkResult("after_bp_50_n6", 33'h1_FFFF_FFF8, 16'd2, 1'b0, 1'b0, 34);
    finishHandshake("after_bp_50_n6");

    // Asynchronous reset in the middle of an iteration
    checkOutput("pre_reset_ready", 64'(up_ready), 64'd1);
    up_numer = 33'd1000;
    up_denom = 16'd3;
    up_valid = 1'b1;
    dn_ready = 1'b1;
    tick();
    up_valid = 1'b0;
    repeat (15) tick();
    rst = 1'b0;
    #1;
    checkOutput("midreset_dn_valid", 64'(dn_valid), 64'd0);
    checkOutput("midreset_quotient", 64'(dn_quotient), 64'd0);
    checkOutput("midreset_remainder", 64'(dn_remainder), 64'd0);
    checkOutput("midreset_flags", 64'({dn_div_zero, dn_overflow}), 64'd0);
    checkOutput("midreset_up_ready", 64'(up_ready), 64'd0);
    tick();
    rst = 1'b1;
    tick();
    checkOutput("midreset_release_ready", 64'(up_ready), 64'd1);

    applyStimulus(33'd9, 16'd4, 1'b1);
    checkResult("post_reset_9_4", 33'd2, 16'd1, 1'b0, 1'b0, 34);
    finishHandshake("post_reset_9_4");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
